// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the dynamic branch predictor and the decode stage:
//   - BT / BF opcode values (decode uses these to drive lookup_is_branch)
//   - default parameter values for branch_predictor_bht
//   - ctr_t, the saturating-counter type at the default counter width
// ---------------------------------------------------------------------------
package bp_pkg;

  // Conditional-branch opcodes (branch-if-true / branch-if-false).
  localparam int         OPCODE_W = 5;
  localparam logic [4:0] BT       = 5'd23;
  localparam logic [4:0] BF       = 5'd24;

  // Default predictor geometry.
  localparam int DEF_PC_W     = 13;
  localparam int DEF_OFFSET_W = 17;
  localparam int DEF_INDEX_W  = 6;
  localparam int DEF_CTR_W    = 2;
  localparam int DEF_INIT_CTR = 1;   // weakly not-taken for a 2-bit counter
  localparam int DEF_STAT_W   = 32;

  typedef logic [DEF_CTR_W-1:0] ctr_t;

endpackage : bp_pkg

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
// Width-parametrised up/down counter that saturates at 0 and at all-ones.
// Used both as a BHT entry (up = resolved taken) and, with up tied high,
// as a saturating event counter for the statistics.
//
// Ports:
//   clk        in   clock
//   reset_low  in   asynchronous active-low reset, loads INIT
//   en         in   count this cycle
//   up         in   1 = increment, 0 = decrement
//   count      out  WIDTH-bit current value
// ---------------------------------------------------------------------------
module bp_sat_counter #(
  parameter int WIDTH = 2,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_V  = '1;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      count <= INIT_V;
    end else if (en) begin
      if (up) begin
        if (count != MAX_V) count <= count + ONE_V;
      end else begin
        if (count != '0) count <= count - ONE_V;
      end
    end
  end

endmodule : bp_sat_counter

// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
// Dynamic branch predictor: a table of 2**INDEX_W saturating counters
// indexed by the low PC bits. Lookup is combinational (zero latency);
// execute writes the resolved outcome back one cycle later through the
// index that was carried down the pipe. Also keeps saturating counts of
// resolved branches and mispredictions for debug.
//
// Build option: define BP_GSHARE_EN to XOR an INDEX_W-bit global history
// register into the lookup index. The port list is the same either way.
//
// Ports:
//   clk                   in   clock
//   reset_low             in   asynchronous active-low reset
//   halted                in   debug halt; freezes table, history, stats
//   lookup_is_branch      in   decode instruction is BT or BF
//   lookup_pc             in   PC of the decode instruction
//   lookup_offset         in   signed branch offset from the instruction
//   predict_taken         out  prediction for the current lookup
//   predicted_offset      out  offset fetch adds this cycle
//   not_predicted_offset  out  recovery offset used on a flush
//   lookup_index          out  table index used (travel with the branch)
//   update_valid          in   branch resolved in execute this cycle
//   update_index          in   lookup_index carried with that branch
//   update_taken          in   resolved outcome
//   update_mispredict     in   resolved branch was mispredicted
//   branch_count          out  resolved branches (saturating)
//   mispredict_count      out  mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int CTR_W    = DEF_CTR_W,
  parameter int INIT_CTR = DEF_INIT_CTR,
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic                clk,
  input  logic                reset_low,
  input  logic                halted,
  input  logic                lookup_is_branch,
  input  logic [PC_W-1:0]     lookup_pc,
  input  logic [OFFSET_W-1:0] lookup_offset,
  output logic                predict_taken,
  output logic [OFFSET_W-1:0] predicted_offset,
  output logic [OFFSET_W-1:0] not_predicted_offset,
  output logic [INDEX_W-1:0]  lookup_index,
  input  logic                update_valid,
  input  logic [INDEX_W-1:0]  update_index,
  input  logic                update_taken,
  input  logic                update_mispredict,
  output logic [STAT_W-1:0]   branch_count,
  output logic [STAT_W-1:0]   mispredict_count
);

  localparam int                  DEPTH      = 2 ** INDEX_W;
  localparam logic [OFFSET_W-1:0] OFFSET_ONE = OFFSET_W'(1);

  // A resolved branch only changes state while the core is running.
  logic upd_en;
  assign upd_en = update_valid & ~halted;

  // -------------------------------------------------------------------------
  // Branch history table
  // -------------------------------------------------------------------------
  logic [CTR_W-1:0] ctr [DEPTH];

  // NOTE: the table is built from individual flops rather than a RAM macro,
  // so every entry can take the asynchronous reset value directly.
  for (genvar i = 0; i < DEPTH; i++) begin : g_bht
    bp_sat_counter #(
      .WIDTH (CTR_W),
      .INIT  (INIT_CTR)
    ) u_ctr (
      .clk       (clk),
      .reset_low (reset_low),
      .en        (upd_en && (update_index == INDEX_W'(i))),
      .up        (update_taken),
      .count     (ctr[i])
    );
  end

  // -------------------------------------------------------------------------
  // Index generation
  // -------------------------------------------------------------------------
`ifdef BP_GSHARE_EN
  // Global history of resolved outcomes, newest in bit 0.
  logic [INDEX_W-1:0] ghr;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      ghr <= '0;
    end else if (upd_en) begin
      ghr <= {ghr[INDEX_W-2:0], update_taken};
    end
  end

  assign lookup_index = lookup_pc[INDEX_W-1:0] ^ ghr;
`else
  assign lookup_index = lookup_pc[INDEX_W-1:0];
`endif

  // PC bits above the index do not take part in the prediction.
  if (PC_W > INDEX_W) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^lookup_pc[PC_W-1:INDEX_W];
  end

  // -------------------------------------------------------------------------
  // Lookup: reads the registered table, so a same-cycle update to the same
  // entry is seen only from the following cycle.
  // -------------------------------------------------------------------------
  logic [CTR_W-1:0] lookup_ctr;
  logic             ctr_says_taken;

  assign lookup_ctr     = ctr[lookup_index];
  assign ctr_says_taken = lookup_ctr[CTR_W-1];
  assign predict_taken  = lookup_is_branch & ctr_says_taken;

  // Fetch adds predicted_offset now; on a flush it uses the other path.
  // NOTE: both outputs get a default before any branch so no path through
  // the block leaves them unassigned, which would infer a latch.
  always_comb begin
    predicted_offset     = OFFSET_ONE;
    not_predicted_offset = OFFSET_ONE;
    if (lookup_is_branch) begin
      if (ctr_says_taken) begin
        predicted_offset     = lookup_offset;
      end else begin
        not_predicted_offset = lookup_offset;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Debug statistics
  // -------------------------------------------------------------------------
  bp_sat_counter #(
    .WIDTH (STAT_W),
    .INIT  (0)
  ) u_branch_count (
    .clk       (clk),
    .reset_low (reset_low),
    .en        (upd_en),
    .up        (1'b1),
    .count     (branch_count)
  );

  bp_sat_counter #(
    .WIDTH (STAT_W),
    .INIT  (0)
  ) u_mispredict_count (
    .clk       (clk),
    .reset_low (reset_low),
    .en        (upd_en & update_mispredict),
    .up        (1'b1),
    .count     (mispredict_count)
  );

endmodule : branch_predictor_bht
